// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_NBITS    = 8;
  localparam int unsigned FETCH_IWIDTH   = 32;
  localparam int unsigned FETCH_RESET_PC = 0;
  localparam int unsigned LINK_OFFSET    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection: jalr target, pc-relative branch, or fall-through.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned NBITS = FETCH_NBITS
) (
  input  logic [NBITS-1:0] i_pc,
  input  logic [NBITS-1:0] i_imm,
  input  logic [NBITS-1:0] i_pcreg,
  input  logic             i_branch,
  input  logic             i_jalr,
  output logic [NBITS-1:0] o_next_pc,
  output logic [NBITS-1:0] o_link
);

  localparam logic [NBITS-1:0] W_LINK = NBITS'(LINK_OFFSET);

  logic [NBITS-1:0] w_jalr_sum;
  logic [NBITS-1:0] w_jalr_target;
  logic [NBITS-1:0] w_branch_target;

  // IMM already spans NBITS, so two's-complement wrap gives signed offsets for free.
  always_comb begin
    w_jalr_sum      = i_pcreg + i_imm;
    w_jalr_target   = {w_jalr_sum[NBITS-1:2], 2'b00};
    w_branch_target = i_pc + i_imm;
    o_link          = i_pc + W_LINK;
    if (i_jalr) begin
      o_next_pc = w_jalr_target;
    end else if (i_branch) begin
      o_next_pc = w_branch_target;
    end else begin
      o_next_pc = o_link;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests words from instruction memory, presents them
// to the controller, and redirects on branch, jalr or flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned NBITS    = FETCH_NBITS,
  parameter int unsigned IWIDTH   = FETCH_IWIDTH,
  parameter int unsigned RESET_PC = FETCH_RESET_PC
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [NBITS-3:0]  imem_addr,
  input  logic              imem_ack,
  input  logic [IWIDTH-1:0] imem_rdata,
  output logic [IWIDTH-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [NBITS-1:0]  pc,
  output logic [NBITS-1:0]  pclink,
  input  logic              branch,
  input  logic              jalr,
  input  logic [NBITS-1:0]  IMM,
  input  logic [NBITS-1:0]  PCReg,
  input  logic              flush,
  input  logic [NBITS-1:0]  flush_pc,
  output logic [15:0]       retired
);

  localparam logic [NBITS-1:0] W_RESET_PC = NBITS'(RESET_PC);

  fetch_state_e      r_state;
  logic [NBITS-1:0]  r_pc;
  logic [NBITS-3:0]  r_addr;
  logic [IWIDTH-1:0] r_instr;
  logic              r_valid;
  logic              r_req;
  logic [15:0]       r_retired;

  logic [NBITS-1:0]  w_next_pc;
  logic [NBITS-1:0]  w_link;

  fetch_next_pc #(
    .NBITS (NBITS)
  ) u_next_pc (
    .i_pc      (r_pc),
    .i_imm     (IMM),
    .i_pcreg   (PCReg),
    .i_branch  (branch),
    .i_jalr    (jalr),
    .o_next_pc (w_next_pc),
    .o_link    (w_link)
  );

  // r_addr is kept apart from r_pc so a flushed request can finish on its
  // original address while r_pc already holds the restart point.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_pc      <= W_RESET_PC;
      r_addr    <= W_RESET_PC[NBITS-1:2];
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_req     <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          r_req   <= 1'b1;
          if (flush) begin
            r_pc   <= flush_pc;
            r_addr <= flush_pc[NBITS-1:2];
          end else begin
            r_addr <= r_pc[NBITS-1:2];
          end
        end
        ST_FETCH: begin
          if (flush) begin
            r_pc <= flush_pc;
            if (imem_ack) begin
              r_addr <= flush_pc[NBITS-1:2];
            end else begin
              r_state <= ST_DISCARD;
            end
          end else if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (flush) begin
            r_valid <= 1'b0;
            r_pc    <= flush_pc;
            r_addr  <= flush_pc[NBITS-1:2];
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end else if (instr_ready) begin
            r_valid   <= 1'b0;
            r_retired <= r_retired + 16'd1;
            r_pc      <= w_next_pc;
            r_addr    <= w_next_pc[NBITS-1:2];
            r_req     <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (flush) begin
            r_pc <= flush_pc;
          end
          if (imem_ack) begin
            r_state <= ST_FETCH;
            r_addr  <= flush ? flush_pc[NBITS-1:2] : r_pc[NBITS-1:2];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    imem_req    = r_req;
    imem_addr   = r_addr;
    instr       = r_instr;
    instr_valid = r_valid;
    pc          = r_pc;
    pclink      = w_link;
    retired     = r_retired;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NBITS, default 8, sets the PC/data width shared with the datapath.
REQ-002 Parameter IWIDTH, default 32, sets the instruction word width.
REQ-003 Parameter RESET_PC, default 0, is the PC value loaded on reset.
REQ-004 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port imem_req, output, 1 bit: instruction-memory request.
REQ-007 Port imem_addr, output, NBITS-2 bits: word address, equal to PC[NBITS-1:2].
REQ-008 Port imem_ack, input, 1 bit: memory returns data this cycle.
REQ-009 Port imem_rdata, input, IWIDTH bits: fetched word, valid with imem_ack.
REQ-010 Port instr, output, IWIDTH bits: instruction presented to the controller.
REQ-011 Port instr_valid, output, 1 bit: instr, pc and pclink are valid.
REQ-012 Port instr_ready, input, 1 bit: the controller consumes instr this cycle.
REQ-013 Port pc, output, NBITS bits: address of instr.
REQ-014 Port pclink, output, NBITS bits: pc+4, the link value fed to the datapath.
REQ-015 Port branch, input, 1 bit: the accepted instruction redirects to pc+IMM.
REQ-016 Port jalr, input, 1 bit: the accepted instruction redirects to (PCReg+IMM) with bits [1:0] cleared.
REQ-017 Port IMM, input, NBITS bits, signed: offset from the controller.
REQ-018 Port PCReg, input, NBITS bits: RS1 value returned from the datapath.
REQ-019 Port flush, input, 1 bit, and flush_pc, input, NBITS bits: asynchronous-to-pipeline restart at flush_pc.
REQ-020 Port retired, output, 16 bits: count of instructions accepted.

Function
REQ-021 FSM states: IDLE, FETCH, HOLD and DISCARD.
REQ-022 IDLE: outputs inactive; the FSM moves to FETCH on the next cycle.
REQ-023 FETCH: imem_req=1 with imem_addr held stable until imem_ack.
REQ-024 FETCH with imem_ack: latch imem_rdata into instr, set instr_valid=1, and move to HOLD.
REQ-025 HOLD: instr, pc and pclink are held stable while instr_ready=0.
REQ-026 HOLD with instr_ready=1: retired increments and the FSM moves to FETCH.
REQ-027 The next PC after HOLD is: jalr target if jalr=1; else pc+IMM if branch=1; else pc+4.
REQ-028 jalr has priority over branch.
REQ-029 branch and jalr are sampled only in a HOLD cycle with instr_ready=1; they are ignored otherwise.
REQ-030 Back-to-back operation: instr_valid drops in the cycle after acceptance; the minimum is one instruction per 2 cycles, plus memory latency.
REQ-031 PC arithmetic is modulo 2^NBITS; with NBITS=8, pc 252 +4 gives 0.
REQ-032 The IMM sign is extended to NBITS; no overflow flag is produced.
REQ-033 flush in FETCH without imem_ack: go to DISCARD and load PC=flush_pc.
REQ-034 DISCARD: hold imem_req=1 and the old address until imem_ack, drop the data, then go to FETCH.
REQ-035 flush in FETCH with imem_ack that same cycle: drop the data, load PC=flush_pc, go to FETCH.
REQ-036 flush in HOLD: clear instr_valid and go to FETCH at flush_pc; retired is not incremented, even if instr_ready=1.
REQ-037 flush in IDLE or DISCARD: update the pending PC to flush_pc.
REQ-038 flush has priority over branch, jalr and instr_ready.
REQ-039 retired wraps from 65535 to 0.
REQ-040 imem_req is never deasserted before imem_ack.

Reset
REQ-041 While reset=0: state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, imem_req=0, and retired=0.
REQ-042 Reset asserted mid-fetch abandons the transaction immediately; the memory must tolerate request withdrawal on reset.
REQ-043 The first imem_req is asserted in the second cycle after reset deasserts.

Structure
REQ-044 Package fetch_pkg holds the state enum, IWIDTH, RESET_PC and the link offset constant 4.
REQ-045 Sub-module fetch_next_pc is the combinational next-PC and jalr target calculator.
REQ-046 fetch_unit instantiates fetch_next_pc once.

Verification
REQ-047 Reset, then 1-cycle ack memory, instr_ready=1: imem_addr sequence 0,1,2,3; pc 0,4,8,12; pclink 4,8,12,16; retired=4.
REQ-048 Accept pc=8 with branch=1, IMM=-8: next imem_addr=0.
REQ-049 Accept pc=8 with jalr=1, PCReg=0x31, IMM=3: next pc=0x34.
REQ-050 Accept with both branch and jalr set: the jalr target wins.
REQ-051 Ack delayed 3 cycles, flush with flush_pc=0x40 in the 2nd wait cycle: imem_req stays high on the old address until ack; that data is never valid; the next fetch is at imem_addr=0x10.
REQ-052 pc=252 falls through: next pc=0; holding instr_ready=0 for 5 cycles keeps instr/pc stable and retired unchanged.
REQ-053 Reset asserted in HOLD: instr_valid=0 immediately; fetch restarts at RESET_PC.
